// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and defaults for the data-memory arbiter slice.
//   arb_state_e : arbiter FSM state (CPU_PRI, DBG_FORCE)
//   port_sel_e  : which requester currently drives the memory port
//   DEFAULT_*   : default parameter values used by the arbiter modules
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      CPU_PRI   = 1'b0,
      DBG_FORCE = 1'b1
   } arb_state_e;

   typedef enum logic {
      SEL_CPU = 1'b0,
      SEL_DBG = 1'b1
   } port_sel_e;

   localparam int DEFAULT_DATA_W     = 32;
   localparam int DEFAULT_ADDR_W     = 32;
   localparam int DEFAULT_DEPTH      = 85;
   localparam int DEFAULT_STARVE_MAX = 4;

endpackage

// File: rtl/dmem_starve_ctr.sv
// -----------------------------------------------------------------------------
// dmem_starve_ctr
// Counts consecutive cycles in which the debug port asks for the memory and
// is refused. Saturates at STARVE_MAX and raises force_o when the next count
// reaches STARVE_MAX, so the arbiter can hand the following cycle to debug.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   dbg_req_i   : debug port is requesting this cycle
//   dbg_gnt_i   : debug port was granted this cycle
//   force_o     : next count equals STARVE_MAX (combinational)
// -----------------------------------------------------------------------------
module dmem_starve_ctr
   import dmem_pkg::*;
#(
   parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dbg_req_i,
   input  logic dbg_gnt_i,
   output logic force_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A grant or an idle debug port ends the starvation run; otherwise each
   // refused cycle adds one, holding at the cap.
   always_comb begin
      cnt_d = cnt_q;
      if (!dbg_req_i || dbg_gnt_i) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_W'(STARVE_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The force decision looks at the next value so the forced grant lands on
   // the cycle right after the STARVE_MAX-th refusal.
   assign force_o = (cnt_d == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-ported data memory between the MEM-stage CPU port and a
// debug/loader port. CPU has fixed priority; a starvation cap forces one
// debug grant. Out-of-range addresses never write and read back as zero.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i : CPU access request
//   cpu_gnt_o, cpu_rdata_o        : CPU grant and load data (combinational)
//   cpu_stall_o                   : CPU requested but was not granted
//   dbg_req_i/we_i/addr_i/wdata_i : debug access request
//   dbg_gnt_o                     : debug grant (combinational)
//   dbg_rvalid_o, dbg_rdata_o     : registered debug read result
//   err_o, err_sticky_o           : out-of-range grant pulse / sticky flag
//   mem_a_o, mem_wd_o, mem_we_o   : memory address, write data, write enable
//   mem_rd_i                      : memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int ADDR_W     = DEFAULT_ADDR_W,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              err_o,
   output logic              err_sticky_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic [DATA_W-1:0] mem_wd_o,
   output logic              mem_we_o,
   input  logic [DATA_W-1:0] mem_rd_i
);

   arb_state_e        state_q;
   port_sel_e         sel;
   logic              cpu_gnt;
   logic              dbg_gnt;
   logic              grant_any;
   logic              granted_we;
   logic              in_range;
   logic              force_next;
   logic              dbg_rvalid_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              err_q;
   logic              err_sticky_q;

   dmem_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .rst_n     (rst_n),
      .dbg_req_i (dbg_req_i),
      .dbg_gnt_i (dbg_gnt),
      .force_o   (force_next)
   );

   // Grant decision: CPU wins in CPU_PRI, debug wins in DBG_FORCE, and the
   // other side picks up the cycle when the preferred one is idle.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      sel     = SEL_CPU;
      case (state_q)
         DBG_FORCE: begin
            if (dbg_req_i) begin
               dbg_gnt = 1'b1;
               sel     = SEL_DBG;
            end else if (cpu_req_i) begin
               cpu_gnt = 1'b1;
            end
         end
         default: begin
            if (cpu_req_i) begin
               cpu_gnt = 1'b1;
            end else if (dbg_req_i) begin
               dbg_gnt = 1'b1;
               sel     = SEL_DBG;
            end
         end
      endcase
   end

   // Arbiter FSM. DBG_FORCE lasts exactly one cycle: either debug takes its
   // grant or it has dropped the request, and either way CPU priority returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CPU_PRI;
      end else begin
         case (state_q)
            CPU_PRI:   if (force_next) state_q <= DBG_FORCE;
            DBG_FORCE: state_q <= CPU_PRI;
            default:   state_q <= CPU_PRI;
         endcase
      end
   end

   // Memory port mux. With no grant the CPU values stay on the bus but the
   // write strobe is held low; reset also gates the strobe immediately.
   always_comb begin
      mem_a_o    = (sel == SEL_DBG) ? dbg_addr_i  : cpu_addr_i;
      mem_wd_o   = (sel == SEL_DBG) ? dbg_wdata_i : cpu_wdata_i;
      granted_we = dbg_gnt ? dbg_we_i : (cpu_gnt & cpu_we_i);
      grant_any  = cpu_gnt | dbg_gnt;
      in_range   = (mem_a_o < ADDR_W'(DEPTH));
      mem_we_o   = rst_n & granted_we & in_range;
   end

   assign cpu_gnt_o   = cpu_gnt;
   assign dbg_gnt_o   = dbg_gnt;
   assign cpu_stall_o = cpu_req_i & ~cpu_gnt;
   assign cpu_rdata_o = (cpu_gnt && in_range) ? mem_rd_i : '0;

   // Registered debug read return and error reporting. Debug read data holds
   // until the next granted debug read; an out-of-range read captures zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         dbg_rvalid_q <= dbg_gnt & ~dbg_we_i;
         if (dbg_gnt && !dbg_we_i) begin
            dbg_rdata_q <= in_range ? mem_rd_i : '0;
         end
         err_q <= grant_any & ~in_range;
         if (grant_any && !in_range) begin
            err_sticky_q <= 1'b1;
         end
      end
   end

   assign dbg_rvalid_o = dbg_rvalid_q;
   assign dbg_rdata_o  = dbg_rdata_q;
   assign err_o        = err_q;
   assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives dmem_arbiter against a small behavioural memory and compares DUT
// outputs with expected values queued up when each stimulus is applied.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DEPTH = 85;
   localparam int SM    = 4;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        err, err_sticky, mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        loadMem;

   logic [31:0] memArr [0:DEPTH-1];
   exp_t        expQ [$];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // Behavioural single-ported memory: combinational read, posedge write.
   // Out-of-range reads return a marker so zero-forcing is observable.
   always @(posedge clk) begin
      if (loadMem) begin
         for (int i = 0; i < DEPTH; i++) memArr[i] <= 32'h1000_0000 + i;
      end else if (mem_we && mem_a < DEPTH) begin
         memArr[mem_a[6:0]] <= mem_wd;
      end
   end

   assign mem_rd = (mem_a < DEPTH) ? memArr[mem_a[6:0]] : 32'hBAD0_BAD0;

   dmem_arbiter #(
      .DATA_W     (32),
      .ADDR_W     (32),
      .DEPTH      (DEPTH),
      .STARVE_MAX (SM)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_we_i     (cpu_we),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_gnt_o    (cpu_gnt),
      .cpu_rdata_o  (cpu_rdata),
      .cpu_stall_o  (cpu_stall),
      .dbg_req_i    (dbg_req),
      .dbg_we_i     (dbg_we),
      .dbg_addr_i   (dbg_addr),
      .dbg_wdata_i  (dbg_wdata),
      .dbg_gnt_o    (dbg_gnt),
      .dbg_rvalid_o (dbg_rvalid),
      .dbg_rdata_o  (dbg_rdata),
      .err_o        (err),
      .err_sticky_o (err_sticky),
      .mem_a_o      (mem_a),
      .mem_wd_o     (mem_wd),
      .mem_we_o     (mem_we),
      .mem_rd_i     (mem_rd)
   );

   // Drive both request ports in one go
   task automatic applyStimulus(input logic cReq, input logic cWe,
                                input logic [31:0] cAddr, input logic [31:0] cWd,
                                input logic dReq, input logic dWe,
                                input logic [31:0] dAddr, input logic [31:0] dWd);
      cpu_req   = cReq;
      cpu_we    = cWe;
      cpu_addr  = cAddr;
      cpu_wdata = cWd;
      dbg_req   = dReq;
      dbg_we    = dWe;
      dbg_addr  = dAddr;
      dbg_wdata = dWd;
   endtask

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Queue an expected value for the next matching sample
   task automatic expectVal(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      expQ.push_back(e);
   endtask

   // Pop the oldest expectation and compare against an observed value
   task automatic popCheck(input logic [31:0] obs);
      exp_t e;
      if (expQ.size() == 0) begin
         checkOutput("sb_underflow", obs, 32'hxxxx_xxxx);
      end else begin
         e = expQ.pop_front();
         checkOutput(e.tag, obs, e.val);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with both ports requesting a write
      loadMem = 1'b1;
      rst_n   = 1'b0;
      applyStimulus(1, 1, 32'd3, 32'h1111_1111, 1, 1, 32'd4, 32'h2222_2222);
      expectVal("rst_rvalid", 0);
      expectVal("rst_rdata", 0);
      expectVal("rst_err", 0);
      expectVal("rst_sticky", 0);
      expectVal("rst_mem_we", 0);
      #12;
      popCheck(dbg_rvalid);
      popCheck(dbg_rdata);
      popCheck(err);
      popCheck(err_sticky);
      popCheck(mem_we);

      // First cycle after release goes to the CPU
      nextCycle();
      rst_n   = 1'b1;
      loadMem = 1'b0;
      applyStimulus(1, 0, 32'd0, 32'd0, 1, 0, 32'd7, 32'd0);
      expectVal("first_cpu_gnt", 1);
      expectVal("first_dbg_gnt", 0);
      @(negedge clk);
      popCheck(cpu_gnt);
      popCheck(dbg_gnt);
      nextCycle();

      // CPU write then read back
      applyStimulus(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0);
      expectVal("wr_cpu_gnt", 1);
      expectVal("wr_mem_we", 1);
      expectVal("wr_stall", 0);
      @(negedge clk);
      popCheck(cpu_gnt);
      popCheck(mem_we);
      popCheck(cpu_stall);
      nextCycle();
      applyStimulus(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0);
      expectVal("rd_cpu_rdata", 32'hDEAD_BEEF);
      expectVal("rd_stall", 0);
      expectVal("rd_mem_we", 0);
      @(negedge clk);
      popCheck(cpu_rdata);
      popCheck(cpu_stall);
      popCheck(mem_we);
      nextCycle();

      // Starvation: continuous CPU traffic, debug read of address 7
      applyStimulus(1, 0, 32'd1, 32'd0, 1, 0, 32'd7, 32'd0);
      for (int c = 1; c <= SM + 1; c++) begin
         expectVal($sformatf("starve_dbg_gnt_c%0d", c), 32'(c == SM + 1));
         expectVal($sformatf("starve_stall_c%0d", c), 32'(c == SM + 1));
         @(negedge clk);
         popCheck(dbg_gnt);
         popCheck(cpu_stall);
         nextCycle();
      end
      expectVal("dbg_rvalid_pulse", 1);
      expectVal("dbg_rdata_addr7", 32'h1000_0007);
      popCheck(dbg_rvalid);
      popCheck(dbg_rdata);
      applyStimulus(1, 0, 32'd1, 32'd0, 0, 0, 32'd0, 32'd0);
      expectVal("resume_cpu_gnt", 1);
      @(negedge clk);
      popCheck(cpu_gnt);
      nextCycle();
      expectVal("rvalid_drop", 0);
      expectVal("rdata_hold", 32'h1000_0007);
      popCheck(dbg_rvalid);
      popCheck(dbg_rdata);

      // Debug write to last valid word, then one past the end
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'd84, 32'h8484_8484);
      expectVal("dwr84_gnt", 1);
      expectVal("dwr84_mem_we", 1);
      @(negedge clk);
      popCheck(dbg_gnt);
      popCheck(mem_we);
      nextCycle();
      expectVal("dwr84_err", 0);
      popCheck(err);
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'd85, 32'h5555_5555);
      expectVal("dwr85_gnt", 1);
      expectVal("dwr85_mem_we", 0);
      @(negedge clk);
      popCheck(dbg_gnt);
      popCheck(mem_we);
      nextCycle();
      expectVal("dwr85_err", 1);
      expectVal("dwr85_sticky", 1);
      popCheck(err);
      popCheck(err_sticky);
      applyStimulus(1, 0, 32'd84, 32'd0, 0, 0, 32'd0, 32'd0);
      expectVal("rd84_cpu_rdata", 32'h8484_8484);
      @(negedge clk);
      popCheck(cpu_rdata);
      nextCycle();
      expectVal("err_cleared", 0);
      expectVal("sticky_holds", 1);
      popCheck(err);
      popCheck(err_sticky);

      // CPU read and write at the top of the address space
      applyStimulus(1, 0, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'd0, 32'd0);
      expectVal("oor_rd_gnt", 1);
      expectVal("oor_rd_rdata", 0);
      expectVal("oor_rd_mem_we", 0);
      @(negedge clk);
      popCheck(cpu_gnt);
      popCheck(cpu_rdata);
      popCheck(mem_we);
      nextCycle();
      expectVal("oor_rd_err", 1);
      popCheck(err);
      applyStimulus(1, 1, 32'hFFFF_FFFF, 32'h7777_7777, 0, 0, 32'd0, 32'd0);
      expectVal("oor_wr_mem_we", 0);
      @(negedge clk);
      popCheck(mem_we);
      nextCycle();
      expectVal("oor_wr_err", 1);
      popCheck(err);

      // Reset while in DBG_FORCE, then the full wait must repeat
      applyStimulus(1, 0, 32'd1, 32'd0, 1, 0, 32'd7, 32'd0);
      repeat (SM) nextCycle();
      rst_n = 1'b0;
      #2;
      expectVal("midrst_sticky", 0);
      expectVal("midrst_err", 0);
      popCheck(err_sticky);
      popCheck(err);
      rst_n = 1'b1;
      for (int c = 1; c <= SM + 1; c++) begin
         expectVal($sformatf("rewait_dbg_gnt_c%0d", c), 32'(c == SM + 1));
         expectVal($sformatf("rewait_cpu_gnt_c%0d", c), 32'(c != SM + 1));
         @(negedge clk);
         popCheck(dbg_gnt);
         popCheck(cpu_gnt);
         nextCycle();
      end

      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the pipeline's data memory. Shares the single-ported memory (combinational read, write on posedge `clk`) between the MEM-stage load/store port and a debug/loader port. The CPU has fixed priority, with a starvation cap that forces a debug grant. It range-checks addresses, blocks out-of-range writes, and stalls the pipeline when the CPU loses a cycle.

## Interface
- `DATA_W`, 32: data width.
- `ADDR_W`, 32: address width. Word addresses, as applied to the memory.
- `DEPTH`, 85: number of valid memory words; valid addresses are 0..DEPTH-1.
- `STARVE_MAX`, 4: consecutive denied debug cycles before the debug port is forced a grant; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: MEM-stage access request.
- `cpu_we` in 1: write when 1, read when 0.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU store data.
- `cpu_gnt` out 1: access performed this cycle (combinational).
- `cpu_rdata` out DATA_W: load data, valid when `cpu_gnt & ~cpu_we` (combinational).
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`; freezes the pipeline.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`: debug request, same meaning as the CPU signals.
- `dbg_gnt` out 1: debug access performed this cycle (combinational).
- `dbg_rvalid` out 1: registered; one-cycle pulse the cycle after a granted debug read.
- `dbg_rdata` out DATA_W: registered read data; holds its value until the next debug read.
- `err` out 1: registered; one-cycle pulse the cycle after any granted out-of-range access.
- `err_sticky` out 1: set by any out-of-range grant; cleared only by reset.
- `mem_a` out ADDR_W: address to the memory.
- `mem_wd` out DATA_W: write data to the memory.
- `mem_we` out 1: write enable to the memory.
- `mem_rd` in DATA_W: memory read data (combinational).

## Operation
- **Grant rule:** at most one grant per cycle.
- FSM `state ∈ {CPU_PRI, DBG_FORCE}`.
- In CPU_PRI:
  - `cpu_req` → CPU granted.
  - else `dbg_req` → debug granted.
- In DBG_FORCE:
  - `dbg_req` → debug granted and the CPU is stalled.
  - If `dbg_req` has dropped, the CPU is granted normally.
- **Starvation counter `starve_cnt`:** 0..STARVE_MAX, saturating.
  - +1 on each cycle with `dbg_req & ~dbg_gnt`.
  - Cleared to 0 on `dbg_gnt` or `~dbg_req`.
- **Transitions:**
  - CPU_PRI→DBG_FORCE when the next `starve_cnt` value equals STARVE_MAX.
  - DBG_FORCE→CPU_PRI after one debug grant, or immediately if `dbg_req` drops.
- **Memory mux:** `mem_a`/`mem_wd` come from the granted port.
  - With no grant, the CPU values are driven and `mem_we=0`.
- **Write enable:** `mem_we = granted_we & in_range`, where `in_range = (addr < DEPTH)` as an unsigned compare over the full ADDR_W.
- **Out-of-range reads:** `cpu_rdata`=0. The `dbg_rdata` capture is 0 with `dbg_rvalid` still pulsed.
- `cpu_rdata` = `mem_rd` when CPU granted and in range, else 0.

## Timing
- CPU access: zero added latency. Grant, read data and write strobe occur in the same cycle as `cpu_req`.
- Debug read: data appears on `dbg_rdata` with `dbg_rvalid`=1 one cycle after `dbg_gnt`.
- Debug write: takes effect at the posedge closing the grant cycle.
- Maximum debug wait under continuous `cpu_req`: STARVE_MAX denied cycles, then a grant on cycle STARVE_MAX+1.
- **Reset values** (asynchronous, immediate on `rst_n`=0):
  - state=CPU_PRI, `starve_cnt`=0.
  - `dbg_rvalid`=0, `dbg_rdata`=0, `err`=0, `err_sticky`=0.
  - Combinational outputs follow the inputs, with `mem_we` forced 0 while `rst_n`=0.
- Reset mid-FORCE: the pending debug grant is lost and the requester must hold `dbg_req`.
- Requests are sampled every cycle; a requester holds `req`/`addr`/`we`/`wdata` stable until granted.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum (`CPU_PRI`, `DBG_FORCE`).
  - Default DEPTH/STARVE_MAX constants.
  - Port-select encoding (`SEL_CPU`, `SEL_DBG`).
- One natural sub-module, `dmem_starve_ctr`: the saturating counter plus force flag, parameterised by STARVE_MAX.
- Grant, mux, range check and registered debug/err outputs stay in the top level.

## Test plan
- Reset with `cpu_req=dbg_req=1` held → all registered outputs 0, `mem_we`=0. After release, the first cycle grants the CPU.
- CPU write addr 5 data 0xDEADBEEF, then CPU read addr 5 → `mem_we`=1 in cycle 1, `cpu_rdata`=0xDEADBEEF in cycle 2, `cpu_stall`=0 throughout.
- Continuous `cpu_req` plus `dbg_req` read addr 7 (STARVE_MAX=4) → `dbg_gnt`=0 for 4 cycles, 1 on the 5th with `cpu_stall`=1 that cycle. Next cycle `dbg_rvalid`=1 with `dbg_rdata`=mem[7]. CPU grant resumes.
- Debug write addr 84 (last valid) then addr 85 → first write commits. Second has `mem_we`=0, `err` pulses the following cycle, `err_sticky`=1 and stays set.
- CPU read addr 0xFFFF_FFFF → `cpu_gnt`=1, `cpu_rdata`=0, `err` pulse, no memory write.
- Assert `rst_n`=0 while state=DBG_FORCE → state returns to CPU_PRI, `starve_cnt`=0. Re-asserted `dbg_req` waits the full STARVE_MAX again.
